// File: rtl/fifo_wr_arbiter_if.sv
// Write-side bundle between NUM_REQ producers, the arbiter and the FIFO write port.
interface fifo_wr_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0]        req;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic                      fifo_full;
   logic [NUM_REQ-1:0]        gnt;
   logic [NUM_REQ-1:0]        ack;
   logic                      fifo_wr_en;
   logic [DATA_W-1:0]         fifo_data;
   logic                      busy;
   logic [ID_W-1:0]           owner_id;

   // Producers and the FIFO full flag drive the master side; the arbiter is the slave.
   modport master (
      output req, req_last, req_data, fifo_full,
      input  gnt, ack, fifo_wr_en, fifo_data, busy, owner_id
   );

   modport slave (
      input  req, req_last, req_data, fifo_full,
      output gnt, ack, fifo_wr_en, fifo_data, busy, owner_id
   );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-granular arbiter sharing one FIFO write port among NUM_REQ producers.
// Per-requester gating lives in a lane module; the FSM owns grant, beat count and fairness pointer.
module fifo_wr_arbiter_lane #(
   parameter int DATA_W = 8
) (
   input  logic              gnt,
   input  logic              req,
   input  logic              req_last,
   input  logic              fifo_full,
   input  logic [DATA_W-1:0] data,
   output logic              req_hit,
   output logic              ack,
   output logic              last_hit,
   output logic [DATA_W-1:0] data_out
);
   // gnt is only ever set in BURST, so gating by it keeps every output quiet when idle or in reset.
   assign req_hit  = gnt & req;
   assign ack      = gnt & req & ~fifo_full;
   assign last_hit = ack & req_last;
   assign data_out = gnt ? data : '0;
endmodule

module fifo_wr_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 8
) (
   input logic                clk,
   input logic                rst,
   fifo_wr_arbiter_if.slave   bus
);
   localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {IDLE, BURST} state_t;

   state_t                           state;
   logic [NUM_REQ-1:0]               gnt;
   logic                             busy;
   logic [ID_W-1:0]                  owner_id;
   logic [ID_W-1:0]                  last_owner;
   logic [CNT_W-1:0]                 beat_cnt;

   logic [NUM_REQ-1:0]               req_hit;
   logic [NUM_REQ-1:0]               ack;
   logic [NUM_REQ-1:0]               last_hit;
   logic [NUM_REQ-1:0][DATA_W-1:0]   lane_data;
   logic [DATA_W-1:0]                data_sel;
   logic                             wr;
   logic                             owner_req;
   logic                             last_acc;
   logic                             cap_hit;
   logic                             release_now;
   logic [ID_W-1:0]                  winner;

   // First asserted request scanning upward from last+1, wrapping.
   function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] r,
                                                input logic [ID_W-1:0]    last);
      logic [ID_W-1:0] pick;
      logic            found;
      int              idx;
      pick  = '0;
      found = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(last) + k) % NUM_REQ;
         if (!found && r[idx]) begin
            found = 1'b1;
            pick  = ID_W'(idx);
         end
      end
      return pick;
   endfunction

   for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
      fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
         .gnt      (gnt[i]),
         .req      (bus.req[i]),
         .req_last (bus.req_last[i]),
         .fifo_full(bus.fifo_full),
         .data     (bus.req_data[i*DATA_W +: DATA_W]),
         .req_hit  (req_hit[i]),
         .ack      (ack[i]),
         .last_hit (last_hit[i]),
         .data_out (lane_data[i])
      );
   end

   always_comb begin
      data_sel = '0;
      for (int i = 0; i < NUM_REQ; i++) data_sel = data_sel | lane_data[i];
   end

   assign wr          = |ack;
   assign owner_req   = |req_hit;
   assign last_acc    = |last_hit;
   assign cap_hit     = (beat_cnt == CNT_W'(MAX_BURST - 1));
   // Abandon releases without a write; last/cap only count on an accepted beat.
   assign release_now = (state == BURST) & (~owner_req | (wr & (last_acc | cap_hit)));
   assign winner      = rr_pick(bus.req, last_owner);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         gnt        <= '0;
         busy       <= 1'b0;
         owner_id   <= '0;
         beat_cnt   <= '0;
         last_owner <= ID_W'(NUM_REQ - 1);
      end else begin
         case (state)
            IDLE: begin
               if (|bus.req) begin
                  gnt      <= NUM_REQ'(1) << winner;
                  owner_id <= winner;
                  beat_cnt <= '0;
                  busy     <= 1'b1;
                  state    <= BURST;
               end
            end
            BURST: begin
               if (release_now) begin
                  gnt        <= '0;
                  busy       <= 1'b0;
                  last_owner <= owner_id;
                  state      <= IDLE;
               end else if (wr) begin
                  beat_cnt <= beat_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.gnt        = gnt;
   assign bus.ack        = ack;
   assign bus.fifo_wr_en = wr;
   assign bus.fifo_data  = data_sel;
   assign bus.busy       = busy;
   assign bus.owner_id   = owner_id;
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: cycle-by-cycle checks plus a log of every FIFO write.
module tb_fifo_wr_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_cmp = 0;
   int   n_err = 0;
   logic [7:0] wlog[$];
   logic [7:0] wexp[$];

   fifo_wr_arbiter_if #(.NUM_REQ(4), .DATA_W(8)) bus ();

   fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(8), .MAX_BURST(8)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) if (bus.fifo_wr_en) wlog.push_back(bus.fifo_data);

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle's inputs at the falling edge, then settle before checks.
   task automatic cyc(input logic [3:0] r, input logic [3:0] l, input logic [31:0] d,
                      input logic f);
      @(negedge clk);
      bus.req       = r;
      bus.req_last  = l;
      bus.req_data  = d;
      bus.fifo_full = f;
      #1;
   endtask

   function automatic logic [31:0] rep(input logic [7:0] b);
      return {b, b, b, b};
   endfunction

   task automatic chk_wr(input string tag, input logic [3:0] g, input logic [7:0] d);
      chk({tag, "_gnt"}, 32'(bus.gnt), 32'(g));
      chk({tag, "_wr"},  32'(bus.fifo_wr_en), 32'd1);
      chk({tag, "_ack"}, 32'(bus.ack), 32'(g));
      chk({tag, "_dat"}, 32'(bus.fifo_data), 32'(d));
      wexp.push_back(d);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, "_gnt"},  32'(bus.gnt), 32'd0);
      chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
      chk({tag, "_wr"},   32'(bus.fifo_wr_en), 32'd0);
   endtask

   initial begin
      bus.req = '0; bus.req_last = '0; bus.req_data = '0; bus.fifo_full = 1'b0;
      #1;
      chk_idle("rst");
      chk("rst_owner", 32'(bus.owner_id), 32'd0);
      chk("rst_ack",   32'(bus.ack), 32'd0);
      @(negedge clk); rst = 1'b0;

      // T1: single requester, three beats
      cyc(4'b0001, 4'b0000, rep(8'h11), 1'b0); chk_idle("t1_pre");
      cyc(4'b0001, 4'b0000, rep(8'h11), 1'b0); chk_wr("t1_b1", 4'b0001, 8'h11);
      chk("t1_busy", 32'(bus.busy), 32'd1);
      cyc(4'b0001, 4'b0000, rep(8'h22), 1'b0); chk_wr("t1_b2", 4'b0001, 8'h22);
      cyc(4'b0001, 4'b0001, rep(8'h33), 1'b0); chk_wr("t1_b3", 4'b0001, 8'h33);
      cyc(4'b0000, 4'b0000, rep(8'h00), 1'b0); chk_idle("t1_post");
      chk("t1_owner", 32'(bus.owner_id), 32'd0);

      // T2: all request, 2-beat bursts; fresh reset so order is 0,1,2,3,0
      @(negedge clk); rst = 1'b1;
      @(negedge clk); rst = 1'b0;
      for (int b = 0; b < 5; b++) begin
         logic [3:0] g;
         g = 4'b0001 << (b % 4);
         cyc(4'b1111, 4'b0000, 32'h0, 1'b0); chk_idle("t2_gap");
         cyc(4'b1111, 4'b0000, 32'h31211101, 1'b0);
         chk_wr("t2_b1", g, 8'(((b % 4) << 4) | 1));
         cyc(4'b1111, 4'b1111, 32'h32221202, 1'b0);
         chk_wr("t2_b2", g, 8'(((b % 4) << 4) | 2));
      end

      // T3: requester 2 never marks last -> capped at 8; pending 1 wins next
      cyc(4'b0100, 4'b0000, 32'h0, 1'b0); chk_idle("t3_pre");
      for (int k = 0; k < 8; k++) begin
         cyc(4'b0110, 4'b0000, rep(8'hB0 + 8'(k)), 1'b0);
         chk_wr("t3_beat", 4'b0100, 8'hB0 + 8'(k));
      end
      cyc(4'b0110, 4'b0000, 32'h0, 1'b0); chk_idle("t3_cap");
      cyc(4'b0000, 4'b0000, 32'h0, 1'b0);
      chk("t3_next_gnt", 32'(bus.gnt), 32'b0010);
      chk("t3_next_id",  32'(bus.owner_id), 32'd1);
      chk("t3_abandon_wr", 32'(bus.fifo_wr_en), 32'd0);

      // T4: back-pressure mid-burst of requester 1, req_last during stall ignored
      cyc(4'b0010, 4'b0000, 32'h0, 1'b0); chk_idle("t4_pre");
      cyc(4'b0010, 4'b0000, rep(8'hA1), 1'b0); chk_wr("t4_b1", 4'b0010, 8'hA1);
      for (int s = 0; s < 4; s++) begin
         cyc(4'b0010, (s == 1) ? 4'b0010 : 4'b0000, rep(8'hA2), 1'b1);
         chk("t4_stall_wr",  32'(bus.fifo_wr_en), 32'd0);
         chk("t4_stall_ack", 32'(bus.ack), 32'd0);
         chk("t4_stall_gnt", 32'(bus.gnt), 32'b0010);
      end
      cyc(4'b0010, 4'b0000, rep(8'hA2), 1'b0); chk_wr("t4_b2", 4'b0010, 8'hA2);
      cyc(4'b0010, 4'b0010, rep(8'hA3), 1'b0); chk_wr("t4_b3", 4'b0010, 8'hA3);

      // T5: owner 3 abandons after 2 beats; pending 0 follows after one idle cycle
      cyc(4'b1001, 4'b0000, 32'h0, 1'b0); chk_idle("t5_pre");
      cyc(4'b1001, 4'b0000, rep(8'hC1), 1'b0); chk_wr("t5_b1", 4'b1000, 8'hC1);
      cyc(4'b1001, 4'b0000, rep(8'hC2), 1'b0); chk_wr("t5_b2", 4'b1000, 8'hC2);
      cyc(4'b0001, 4'b0000, rep(8'hC3), 1'b0);
      chk("t5_drop_gnt", 32'(bus.gnt), 32'b1000);
      chk("t5_drop_wr",  32'(bus.fifo_wr_en), 32'd0);
      cyc(4'b0001, 4'b0000, 32'h0, 1'b0); chk_idle("t5_gap");
      chk("t5_gap_id", 32'(bus.owner_id), 32'd3);
      cyc(4'b0000, 4'b0000, 32'h0, 1'b0);
      chk("t5_gnt0", 32'(bus.gnt), 32'b0001);
      chk("t5_id0",  32'(bus.owner_id), 32'd0);

      // T6: asynchronous reset mid-burst, then lowest pending index wins
      cyc(4'b0100, 4'b0000, 32'h0, 1'b0); chk_idle("t6_pre");
      cyc(4'b0100, 4'b0000, rep(8'hD1), 1'b0); chk_wr("t6_b1", 4'b0100, 8'hD1);
      cyc(4'b0100, 4'b0000, rep(8'hD2), 1'b0);
      chk("t6_b2_wr", 32'(bus.fifo_wr_en), 32'd1);
      #1 rst = 1'b1;
      #1;
      chk_idle("t6_rst");
      chk("t6_rst_id", 32'(bus.owner_id), 32'd0);
      bus.req = 4'b0110;
      #1 rst = 1'b0;
      cyc(4'b0000, 4'b0000, 32'h0, 1'b0);
      chk("t6_regnt", 32'(bus.gnt), 32'b0010);
      cyc(4'b0000, 4'b0000, 32'h0, 1'b0); chk_idle("t6_end");

      chk("log_count", 32'(wlog.size()), 32'(wexp.size()));
      chk("log_total", 32'(wlog.size()), 32'd27);
      for (int i = 0; i < wexp.size() && i < wlog.size(); i++)
         chk("log_beat", 32'(wlog[i]), 32'(wexp[i]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
